pwm_compare_gen: RTL and testbench

- Downstream consumer of the N-bit up-counter function: an internal free-running modulo counter drives a compare stage that produces a PWM waveform.
- Period and duty are programmable through a valid/ready config port.
- New config is double-buffered and takes effect only at a period boundary, so no runt pulses are produced.
- Sits between the counter library and any LED/motor/timing consumer.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_compare_gen_if.sv | 23 ++
 rtl/pwm_cfg_buffer.sv | 66 ++++++
 rtl/pwm_compare_gen.sv | 99 +++++++++
 tb/tb_pwm_compare_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM compare generator: FSM states and the config record.
package pwm_pkg;

  // Width of the counter, period and duty fields carried in pwm_cfg_t.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
  } pwm_cfg_t;

  // Out-of-reset setting: longest period, waveform held low.
  function automatic pwm_cfg_t reset_cfg();
    pwm_cfg_t c;
    c.period = '1;
    c.duty   = '0;
    return c;
  endfunction

endpackage

// File: rtl/pwm_compare_gen_if.sv
// Valid/ready config port carrying a new period/duty pair.
interface pwm_compare_gen_if #(
  parameter int unsigned LENGTH = 3
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [LENGTH-1:0] cfg_period;
  logic [LENGTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_cfg_buffer.sv
// One-entry pending config slot. While idle, accepted configs go straight to the
// active registers; while counting they wait here until the period boundary.
module pwm_cfg_buffer
  import pwm_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  pwm_cfg_t in_cfg,
  input  logic     busy,
  input  logic     boundary,
  output pwm_cfg_t active,
  output pwm_cfg_t active_next
);

  pwm_cfg_t active_q, active_d;
  pwm_cfg_t pend_q, pend_d;
  logic     pend_valid_q, pend_valid_d;
  logic     accept;
  logic     apply;

  assign in_ready = !pend_valid_q;
  assign accept   = in_valid && in_ready;
  // An apply needs a full slot and an accept needs an empty one, so the two never
  // collide; a config taken on the boundary edge therefore waits a full period.
  assign apply    = busy && boundary && pend_valid_q;

  // Next-state for active and pending registers.
  always_comb begin
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (!busy) begin
      if (accept) begin
        active_d = in_cfg;
      end
    end else begin
      if (apply) begin
        active_d     = pend_q;
        pend_valid_d = 1'b0;
      end
      if (accept) begin
        pend_d       = in_cfg;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Config state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= reset_cfg();
      pend_q       <= reset_cfg();
      pend_valid_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign active      = active_q;
  assign active_next = active_d;

endmodule

// File: rtl/pwm_compare_gen.sv
// PWM generator: free-running modulo counter plus compare stage, with
// double-buffered period/duty that change only at a period boundary.
module pwm_compare_gen
  import pwm_pkg::*;
#(
  parameter int unsigned LENGTH = CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  pwm_compare_gen_if.slave    cfg,
  output logic                pwm_o,
  output logic [LENGTH-1:0]   count_o,
  output logic                period_end_o,
  output logic                busy_o
);

  state_t            state_q, state_d;
  logic [LENGTH-1:0] count_q, count_d;
  logic              pwm_q, pwm_d;
  logic              busy;
  logic              term;
  logic [LENGTH-1:0] count_wrap;
  pwm_cfg_t          in_cfg;
  pwm_cfg_t          active;
  pwm_cfg_t          active_next;

  assign busy       = (state_q != IDLE);
  assign term       = busy && (count_q == active.period);
  assign count_wrap = (count_q == active.period) ? '0 : count_q + LENGTH'(1);

  assign in_cfg.period = cfg.cfg_period;
  assign in_cfg.duty   = cfg.cfg_duty;

  pwm_cfg_buffer u_cfg_buffer (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (cfg.cfg_valid),
    .in_ready    (cfg.cfg_ready),
    .in_cfg      (in_cfg),
    .busy        (busy),
    .boundary    (term),
    .active      (active),
    .active_next (active_next)
  );

  // FSM and counter next-state; pwm is computed from the next count and duty so
  // the registered waveform lines up with the registered count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = count_wrap;
        if (!en) begin
          state_d = term ? IDLE : STOP;
        end
      end
      STOP: begin
        count_d = count_wrap;
        if (en) begin
          state_d = RUN;
        end else if (term) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    pwm_d = (state_d != IDLE) && (count_d < active_next.duty);
  end

  // State, counter and waveform registers; reset aborts without draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign count_o      = count_q;
  assign period_end_o = term;
  assign busy_o       = busy;

endmodule

// File: tb/tb_pwm_compare_gen.sv
// Bench for pwm_compare_gen: directed scenarios plus random traffic, all checked
// against a cycle model built from the period/duty/handshake rules.
module tb_pwm_compare_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_o;
  logic [2:0] count_o;
  logic       period_end_o;
  logic       busy_o;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;

  // Reference model: busy flag, counter, active setting and a pending queue.
  bit       m_busy;
  int       m_cnt;
  int       m_per;
  int       m_duty;
  bit [5:0] m_pend[$];
  bit       m_acc;

  always #5 clk = ~clk;

  pwm_compare_gen_if #(.LENGTH(3)) cfg_if ();

  pwm_compare_gen #(.LENGTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg          (cfg_if),
    .pwm_o        (pwm_o),
    .count_o      (count_o),
    .period_end_o (period_end_o),
    .busy_o       (busy_o)
  );

  assign obs = {count_o, pwm_o, period_end_o, busy_o, cfg_if.cfg_ready};

  function automatic logic [6:0] exp_vec();
    logic [2:0] c;
    c = 3'(m_cnt);
    return {c, m_busy && (m_cnt < m_duty), m_busy && (m_cnt == m_per), m_busy,
            m_pend.size() == 0};
  endfunction

  task automatic model_step();
    bit       acc;
    bit       wrap;
    bit [5:0] c;
    m_acc = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_per  = 7;
      m_duty = 0;
      m_pend.delete();
    end else begin
      acc   = cfg_if.cfg_valid && (m_pend.size() == 0);
      m_acc = acc;
      if (!m_busy) begin
        if (acc) begin
          m_per  = int'(cfg_if.cfg_period);
          m_duty = int'(cfg_if.cfg_duty);
        end
        if (en) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else begin
        wrap = (m_cnt == m_per);
        if (wrap && m_pend.size() > 0) begin
          c      = m_pend.pop_front();
          m_per  = int'(c[5:3]);
          m_duty = int'(c[2:0]);
        end
        if (acc) m_pend.push_back({cfg_if.cfg_period, cfg_if.cfg_duty});
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (!en && wrap) m_busy = 1'b0;
      end
    end
  endtask

  // Advance one clock; model consumes the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) tick();
    total++;
    if (m_busy) begin
      bad++;
      $display("FAIL go_idle timeout busy_o=%b required idle", busy_o);
    end
  endtask

  task automatic start(input int p, input int d);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 3'(p);
    cfg_if.cfg_duty   = 3'(d);
    en = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 20 && m_cnt != c; i++) tick();
    total++;
    if (m_cnt != c) begin
      bad++;
      $display("FAIL run_to timeout count_o=%0d required %0d", count_o, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;
    tick();
    tick();
    total++;
    if (obs !== 7'b000_0_0_0_1) begin
      bad++;
      $display("FAIL reset_state got=%b required=%b", obs, 7'b000_0_0_0_1);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_idle got=%b required=%b", obs, exp_vec());
    end
  endtask

  task automatic test_basic();
    int highs = 0;
    int ends  = 0;
    start(7, 3);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_vec() || count_o !== 3'(i % 8)) begin
        bad++;
        $display("FAIL basic cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
      highs += int'(pwm_o);
      ends  += int'(period_end_o);
    end
    total++;
    if (highs != 9 || ends != 3) begin
      bad++;
      $display("FAIL basic_totals highs=%0d ends=%0d required 9 and 3", highs, ends);
    end
  endtask

  task automatic test_reconfig();
    run_to(2);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 3'd4;
    cfg_if.cfg_duty   = 3'd4;
    tick();
    total++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL reconfig_ready got=%b required=0", cfg_if.cfg_ready);
    end
    // Second offer must stall while the slot is full.
    cfg_if.cfg_period = 3'd6;
    cfg_if.cfg_duty   = 3'd1;
    for (int i = 0; i < 20 && m_cnt != 7; i++) begin
      tick();
      total++;
      if (obs !== exp_vec() || cfg_if.cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL reconfig_stall got=%b required=%b", obs, exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_acc) cfg_if.cfg_valid = 1'b0;
      total++;
      if (obs !== exp_vec() || count_o !== 3'(i) || pwm_o !== (i < 4)) begin
        bad++;
        $display("FAIL reconfig_new cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_stop();
    int n = 0;
    go_idle();
    start(7, 3);
    run_to(2);
    en = 1'b0;
    while (m_busy && n < 20) begin
      tick();
      n++;
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL stop_drain cyc=%0d got=%b required=%b", n, obs, exp_vec());
      end
    end
    total++;
    if (n != 6 || obs !== 7'b000_0_0_0_1) begin
      bad++;
      $display("FAIL stop_idle cycles=%0d got=%b required 6 and 0000001", n, obs);
    end
    start(7, 3);
    run_to(2);
    en = 1'b0;
    run_to(5);
    en = 1'b1;
    tick();
    total++;
    if (count_o !== 3'd6 || busy_o !== 1'b1 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL stop_resume count_o=%0d busy_o=%b required 6 and 1", count_o, busy_o);
    end
  endtask

  task automatic test_duty_corners();
    int per[3]  = '{5, 5, 0};
    int duty[3] = '{0, 6, 1};
    for (int k = 0; k < 3; k++) begin
      go_idle();
      start(per[k], duty[k]);
      for (int j = 0; j < 14; j++) begin
        if (j > 0) tick();
        total++;
        if (obs !== exp_vec() || pwm_o !== (k != 0) ||
            (k == 2 && (count_o !== 3'd0 || period_end_o !== 1'b1))) begin
          bad++;
          $display("FAIL corner k=%0d cyc=%0d got=%b required=%b", k, j, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    int maxc  = 0;
    go_idle();
    start(7, 3);
    run_to(1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 3'd2;
    cfg_if.cfg_duty   = 3'd1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    run_to(4);
    rst = 1'b1;
    tick();
    total++;
    if (obs !== 7'b000_0_0_0_1) begin
      bad++;
      $display("FAIL reset_mid got=%b required=0000001", obs);
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL reset_mid_run cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
      highs += int'(pwm_o);
      if (int'(count_o) > maxc) maxc = int'(count_o);
    end
    total++;
    if (highs != 0 || maxc != 7) begin
      bad++;
      $display("FAIL reset_mid_discard highs=%0d maxcount=%0d required 0 and 7", highs, maxc);
    end
  endtask

  task automatic test_boundary_cfg();
    go_idle();
    start(7, 3);
    run_to(7);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 3'd3;
    cfg_if.cfg_duty   = 3'd2;
    tick();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (count_o !== 3'd0 || cfg_if.cfg_ready !== 1'b0 || pwm_o !== 1'b1) begin
      bad++;
      $display("FAIL boundary_hold got=%b required count 0 ready 0 pwm 1", obs);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (obs !== exp_vec() || count_o !== 3'(i)) begin
        bad++;
        $display("FAIL boundary_old cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (obs !== exp_vec() || count_o !== 3'(i % 4) || pwm_o !== ((i % 4) < 2)) begin
        bad++;
        $display("FAIL boundary_new cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) en = ~en;
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_period = 3'($urandom_range(0, 7));
      cfg_if.cfg_duty   = 3'($urandom_range(0, 7));
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b required=%b", i, obs, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_busy = 1'b0;
    m_cnt  = 0;
    m_per  = 7;
    m_duty = 0;
    test_reset();
    test_basic();
    test_reconfig();
    test_stop();
    test_duty_corners();
    test_reset_mid();
    test_boundary_cfg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
